i2c_reg_ctrl: RTL and testbench

Transaction controller between the `i2c_simple_slave` strobe interface and a simple register bus. It decodes the byte stream into a register pointer, register writes and register reads. It holds the slave in clock-stretch (`stall`) while a register access is outstanding and keeps the slave's transmit byte loaded. It sits between the I2C slave and the device's register file or peripheral bus.

---
 rtl/i2c_reg_ctrl_if.sv | 36 +++
 rtl/i2c_reg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_ctrl_if.sv
// Strobe interface from the I2C slave plus the simple register bus.
// The master modport is the controller's view; slave is the environment's view.
interface i2c_reg_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 4
);
  logic [7:0]            i2c_addr_rw;
  logic                  i2c_addr_rw_valid_stb;
  logic [7:0]            i2c_data_rx;
  logic                  i2c_data_rx_valid_stb;
  logic                  i2c_data_tx_loaded_stb;
  logic                  i2c_data_tx_done_stb;
  logic                  i2c_error_stb;
  logic                  stall;
  logic [7:0]            i2c_data_tx;
  logic                  reg_req;
  logic                  reg_we;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic [7:0]            reg_rdata;
  logic                  reg_ack;
  logic                  timeout_stb;

  modport master (
    input  i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
    input  i2c_data_tx_loaded_stb, i2c_data_tx_done_stb, i2c_error_stb,
    input  reg_rdata, reg_ack,
    output stall, i2c_data_tx, reg_req, reg_we, reg_addr, reg_wdata, timeout_stb
  );

  modport slave (
    output i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
    output i2c_data_tx_loaded_stb, i2c_data_tx_done_stb, i2c_error_stb,
    output reg_rdata, reg_ack,
    input  stall, i2c_data_tx, reg_req, reg_we, reg_addr, reg_wdata, timeout_stb
  );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// Transaction controller: turns the I2C slave byte stream into a register pointer,
// register writes and (prefetching) register reads, stretching the clock while a
// bus access is outstanding.
module i2c_reg_ctrl #(
  parameter logic [6:0]  I2C_ADDRESS = 7'h42,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic            clk,
  input logic            rst_n,
  i2c_reg_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StPtr,
    StWrData,
    StWrBus,
    StRdBus,
    StRdHold
  } state_e;

  // Counter value seen in the last cycle a request may stay up without an ack.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            tx_q, tx_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  tmo_stb_q, tmo_stb_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  launch;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  unused_loaded;

  assign unused_loaded = bus.i2c_data_tx_loaded_stb;

  // Ack beats a coinciding timeout.
  assign ack_hit     = req_q & bus.reg_ack;
  assign timeout_hit = req_q & ~bus.reg_ack & (cnt_q == TimeoutLast);

  // Next-state decode; error strobe first, then address strobe, then per-state events.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    req_d     = req_q;
    we_d      = we_q;
    tmo_stb_d = 1'b0;
    launch    = 1'b0;

    if (bus.i2c_error_stb) begin
      req_d   = 1'b0;
      state_d = StIdle;
    end else if (bus.i2c_addr_rw_valid_stb) begin
      req_d = 1'b0;
      if (bus.i2c_addr_rw[7:1] != I2C_ADDRESS) begin
        state_d = StIdle;
      end else if (!bus.i2c_addr_rw[0]) begin
        state_d = StPtr;
      end else begin
        addr_d  = ptr_q;
        we_d    = 1'b0;
        req_d   = 1'b1;
        launch  = 1'b1;
        state_d = StRdBus;
      end
    end else begin
      unique case (state_q)
        StPtr: begin
          if (bus.i2c_data_rx_valid_stb) begin
            ptr_d   = bus.i2c_data_rx[REG_ADDR_W-1:0];
            state_d = StWrData;
          end
        end
        StWrData: begin
          if (bus.i2c_data_rx_valid_stb) begin
            addr_d  = ptr_q;
            wdata_d = bus.i2c_data_rx;
            we_d    = 1'b1;
            req_d   = 1'b1;
            launch  = 1'b1;
            state_d = StWrBus;
          end
        end
        StWrBus: begin
          // A timed-out write is dropped but still consumes its pointer slot.
          if (ack_hit || timeout_hit) begin
            req_d     = 1'b0;
            ptr_d     = ptr_q + REG_ADDR_W'(1);
            tmo_stb_d = timeout_hit;
            state_d   = StWrData;
          end
        end
        StRdBus: begin
          if (ack_hit) begin
            tx_d    = bus.reg_rdata;
            req_d   = 1'b0;
            state_d = StRdHold;
          end else if (timeout_hit) begin
            tx_d      = 8'hFF;
            req_d     = 1'b0;
            tmo_stb_d = 1'b1;
            state_d   = StRdHold;
          end
        end
        StRdHold: begin
          // Speculative prefetch of the next register once the byte has gone out.
          if (bus.i2c_data_tx_done_stb) begin
            ptr_d   = ptr_q + REG_ADDR_W'(1);
            addr_d  = ptr_q + REG_ADDR_W'(1);
            we_d    = 1'b0;
            req_d   = 1'b1;
            launch  = 1'b1;
            state_d = StRdBus;
          end
        end
        default: ;
      endcase
    end

    // Counts cycles the current request has been up; restarts on every new request.
    cnt_d = (req_d && !launch) ? cnt_q + 16'd1 : 16'd0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      tmo_stb_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      req_q     <= req_d;
      we_q      <= we_d;
      tmo_stb_q <= tmo_stb_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stall tracks the request flop so it can never be up without reg_req.
  assign bus.stall       = req_q;
  assign bus.reg_req     = req_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.i2c_data_tx = tx_q;
  assign bus.timeout_stb = tmo_stb_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed plus randomized bench for i2c_reg_ctrl. The bench plays both the I2C
// slave and the register file; a pointer/memory model predicts every bus access.
module tb_i2c_reg_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_ctrl_if #(.REG_ADDR_W(AW)) bus ();

  i2c_reg_ctrl #(
    .I2C_ADDRESS(7'h42),
    .REG_ADDR_W (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         ptr    = 0;
  logic [7:0] mem [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".req"}, 32'(bus.reg_req), 32'd0);
    check({tag, ".stall"}, 32'(bus.stall), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check({tag, ".we"}, 32'(bus.reg_we), 32'd0);
    check({tag, ".addr"}, 32'(bus.reg_addr), 32'd0);
    check({tag, ".wdata"}, 32'(bus.reg_wdata), 32'd0);
    check({tag, ".tx"}, 32'(bus.i2c_data_tx), 32'd0);
    check({tag, ".tmo"}, 32'(bus.timeout_stb), 32'd0);
  endtask

  task automatic send_addr(input logic [7:0] b);
    bus.i2c_addr_rw           = b;
    bus.i2c_addr_rw_valid_stb = 1'b1;
    tick();
    bus.i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.i2c_data_rx           = b;
    bus.i2c_data_rx_valid_stb = 1'b1;
    tick();
    bus.i2c_data_rx_valid_stb = 1'b0;
  endtask

  task automatic send_done();
    bus.i2c_data_tx_done_stb = 1'b1;
    tick();
    bus.i2c_data_tx_done_stb = 1'b0;
  endtask

  // Called in the first cycle of a request; acks after lat cycles.
  task automatic service(input string tag, input bit we, input int addr,
                         input logic [7:0] wdata, input int lat, input logic [7:0] rdata);
    check({tag, ".req"}, 32'(bus.reg_req), 32'd1);
    check({tag, ".stall"}, 32'(bus.stall), 32'd1);
    check({tag, ".we"}, 32'(bus.reg_we), 32'(we));
    check({tag, ".addr"}, 32'(bus.reg_addr), 32'(addr % 16));
    if (we) check({tag, ".wdata"}, 32'(bus.reg_wdata), 32'(wdata));
    for (int i = 0; i < lat; i++) begin
      tick();
      check({tag, ".hold_req"}, 32'(bus.reg_req), 32'd1);
      check({tag, ".hold_stall"}, 32'(bus.stall), 32'd1);
    end
    bus.reg_rdata = rdata;
    bus.reg_ack   = 1'b1;
    tick();
    bus.reg_ack   = 1'b0;
    check({tag, ".done_req"}, 32'(bus.reg_req), 32'd0);
    check({tag, ".done_stall"}, 32'(bus.stall), 32'd0);
    check({tag, ".done_tmo"}, 32'(bus.timeout_stb), 32'd0);
    if (!we) check({tag, ".tx"}, 32'(bus.i2c_data_tx), 32'(rdata));
  endtask

  // One data byte of a write burst: lands at the pointer, pointer advances.
  task automatic write_byte(input logic [7:0] d, input int lat);
    send_rx(d);
    service("wr", 1'b1, ptr, d, lat, 8'h00);
    mem[ptr] = d;
    ptr = (ptr + 1) % 16;
  endtask

  // One byte of a read burst; every byte after the first follows a tx_done.
  task automatic read_byte(input bit first, input int lat);
    if (!first) begin
      send_done();
      ptr = (ptr + 1) % 16;
    end
    service("rd", 1'b0, ptr, 8'h00, lat, mem[ptr]);
  endtask

  initial begin
    logic [7:0] b;
    logic [6:0] a;
    int         n;

    bus.i2c_addr_rw            = '0;
    bus.i2c_addr_rw_valid_stb  = 1'b0;
    bus.i2c_data_rx            = '0;
    bus.i2c_data_rx_valid_stb  = 1'b0;
    bus.i2c_data_tx_loaded_stb = 1'b0;
    bus.i2c_data_tx_done_stb   = 1'b0;
    bus.i2c_error_stb          = 1'b0;
    bus.reg_rdata              = '0;
    bus.reg_ack                = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_in");
    rst_n = 1'b1;
    tick();
    check_all_zero("rst_out");

    // Pointer 3, two writes with 3-cycle ack latency
    send_addr(8'h84);
    check_quiet("tp1_addr");
    send_rx(8'h03);
    check_quiet("tp1_ptr");
    ptr = 3;
    write_byte(8'hA5, 3);
    write_byte(8'h5A, 3);
    send_addr(8'h85);
    read_byte(1'b1, 0);  // pointer must be 5

    // Pointer 0x0F, repeated-start read wraps to 0, third read prefetched at 1
    send_addr(8'h84);
    send_rx(8'h0F);
    ptr = 15;
    mem[15] = 8'h11;
    mem[0]  = 8'h22;
    send_addr(8'h85);
    read_byte(1'b1, 1);
    read_byte(1'b0, 0);
    read_byte(1'b0, 2);

    // Address mismatch: data bytes ignored, pointer untouched
    send_addr(8'h86);
    check_quiet("mis_addr");
    for (int i = 0; i < 3; i++) begin
      send_rx(8'($urandom));
      check_quiet("mis_rx");
    end
    send_addr(8'h85);
    read_byte(1'b1, 0);

    // Read timeout: 4 request cycles, one-cycle pulse, tx forced to FF
    send_addr(8'h85);
    check("rtmo.req0", 32'(bus.reg_req), 32'd1);
    check("rtmo.addr", 32'(bus.reg_addr), 32'(ptr));
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      check("rtmo.req", 32'(bus.reg_req), 32'd1);
      check("rtmo.pulse_early", 32'(bus.timeout_stb), 32'd0);
    end
    tick();
    check("rtmo.req_drop", 32'(bus.reg_req), 32'd0);
    check("rtmo.stall_drop", 32'(bus.stall), 32'd0);
    check("rtmo.pulse", 32'(bus.timeout_stb), 32'd1);
    check("rtmo.tx", 32'(bus.i2c_data_tx), 32'hFF);
    tick();
    check("rtmo.pulse_end", 32'(bus.timeout_stb), 32'd0);
    read_byte(1'b0, 1);

    // Write timeout: byte dropped, pointer still advances
    send_addr(8'h84);
    send_rx(8'h09);
    ptr = 9;
    send_rx(8'h77);
    check("wtmo.req0", 32'(bus.reg_req), 32'd1);
    check("wtmo.we", 32'(bus.reg_we), 32'd1);
    repeat (TO - 1) tick();
    tick();
    check("wtmo.req_drop", 32'(bus.reg_req), 32'd0);
    check("wtmo.pulse", 32'(bus.timeout_stb), 32'd1);
    ptr = 10;
    tick();
    write_byte(8'h88, 0);

    // Error strobe coinciding with ack on a pending write
    send_addr(8'h84);
    send_rx(8'h07);
    ptr = 7;
    send_rx(8'h33);
    check("err.req0", 32'(bus.reg_req), 32'd1);
    tick();
    bus.i2c_error_stb = 1'b1;
    bus.reg_ack       = 1'b1;
    tick();
    bus.i2c_error_stb = 1'b0;
    bus.reg_ack       = 1'b0;
    check_quiet("err.drop");
    check("err.tmo", 32'(bus.timeout_stb), 32'd0);
    send_rx(8'h44);
    check_quiet("err.idle");
    send_addr(8'h85);
    read_byte(1'b1, 0);  // pointer must still be 7

    // Randomized transactions against the pointer/memory model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          send_addr(8'h84);
          b = 8'($urandom);
          send_rx(b);
          ptr = int'(b) % 16;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) write_byte(8'($urandom), $urandom_range(0, TO - 1));
        end
        1: begin
          send_addr(8'h85);
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) read_byte(k == 0, $urandom_range(0, TO - 1));
        end
        default: begin
          do a = 7'($urandom); while (a == 7'h42);
          send_addr({a, 1'($urandom)});
          check_quiet("rnd_mis");
          send_rx(8'($urandom));
          check_quiet("rnd_mis_rx");
        end
      endcase
    end

    // Asynchronous reset in the middle of a read
    send_addr(8'h85);
    check("arst.req0", 32'(bus.reg_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    #2;
    rst_n = 1'b1;
    ptr = 0;
    tick();
    send_addr(8'h85);
    read_byte(1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
